alu_result_checker: RTL and testbench

//   Receiving end of the 8-bit add/sub ALU stimulus interface. Accepts
//   (a, b, controle, s) vectors over a valid/ready handshake.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_ref_model.sv | 22 ++
 rtl/alu_result_checker.sv | 161 ++++++++++++++++
 tb/tb_alu_result_checker.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the add/sub ALU result checker.
//   OP_ADD / OP_SUB : encoding of the controle input (1 = add, 0 = subtract)
//   state_e         : checker FSM state encoding
//   DEF_WIDTH       : default operand/result width
//   DEF_CNT_W       : default width of vector/error counters
package alu_pkg;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_ref_model.sv
// Golden model of the add/sub ALU (purely combinational).
//   a_i, b_i     : operands
//   controle_i   : OP_ADD -> a+b, OP_SUB -> a-b
//   expected_o   : result modulo 2^WIDTH (carry/borrow dropped)
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             controle_i,
  output logic [WIDTH-1:0] expected_o
);

  // WIDTH-bit arithmetic: the carry/borrow out simply falls off the top.
  always_comb begin
    if (controle_i == OP_ADD) expected_o = a_i + b_i;
    else                      expected_o = a_i - b_i;
  end

endmodule

// File: rtl/alu_result_checker.sv
// Receiving end of the add/sub ALU stimulus interface.
// Accepts (a, b, controle, s) vectors, recomputes the expected result,
// counts vectors and mismatches, captures the first mismatch and raises
// done/pass once num_vec vectors have been checked.
//
// Ports:
//   clk, rst_n      : clock (rising edge), synchronous active-low reset
//   start, num_vec  : one-cycle run start (IDLE/DONE only) and run length
//   in_valid/in_ready, a, b, controle, s : vector input channel
//   done, pass      : run complete / complete with no mismatches
//   vec_count, err_count : accepted vectors / mismatches (saturating)
//   first_err_idx/exp/got: index, expected value and s of first mismatch
//   dbg_state       : current FSM state
//
// Handshake: a vector transfers on a rising edge where in_valid && in_ready.
// in_ready depends only on the FSM state (high only in RUN); in_valid may
// be dropped between vectors and is ignored outside RUN.
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_vec,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             controle,
  input  logic [WIDTH-1:0] s,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx,
  output logic [WIDTH-1:0] first_err_exp,
  output logic [WIDTH-1:0] first_err_got,
  output state_e           dbg_state
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d;
  logic [CNT_W-1:0] vec_cnt_q, vec_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] ferr_idx_q, ferr_idx_d;
  logic [WIDTH-1:0] ferr_exp_q, ferr_exp_d;
  logic [WIDTH-1:0] ferr_got_q, ferr_got_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [WIDTH-1:0] expected;
  logic             accept;
  logic             mismatch;
  logic             last_vec;

  alu_ref_model #(.WIDTH(WIDTH)) u_ref (
    .a_i        (a),
    .b_i        (b),
    .controle_i (controle),
    .expected_o (expected)
  );

  assign in_ready = (state_q == ST_RUN);
  assign accept   = in_valid && in_ready;
  assign mismatch = accept && (s != expected);
  assign last_vec = (vec_cnt_q == num_q - CNT_W'(1));

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    vec_cnt_d  = vec_cnt_q;
    err_cnt_d  = err_cnt_q;
    ferr_idx_d = ferr_idx_q;
    ferr_exp_d = ferr_exp_q;
    ferr_got_d = ferr_got_q;
    done_d     = done_q;
    pass_d     = pass_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          num_d      = num_vec;
          vec_cnt_d  = '0;
          err_cnt_d  = '0;
          ferr_idx_d = '0;
          ferr_exp_d = '0;
          ferr_got_d = '0;
          if (num_vec == '0) begin
            // Empty run completes immediately and trivially passes.
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = 1'b1;
          end else begin
            state_d = ST_RUN;
            done_d  = 1'b0;
            pass_d  = 1'b0;
          end
        end
      end

      ST_RUN: begin
        if (accept) begin
          vec_cnt_d = vec_cnt_q + CNT_W'(1);
          if (mismatch) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
            // err_count never wraps, so zero means no mismatch seen yet.
            if (err_cnt_q == '0) begin
              ferr_idx_d = vec_cnt_q;
              ferr_exp_d = expected;
              ferr_got_d = s;
            end
          end
          if (last_vec) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            pass_d  = (err_cnt_d == '0);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      num_q      <= '0;
      vec_cnt_q  <= '0;
      err_cnt_q  <= '0;
      ferr_idx_q <= '0;
      ferr_exp_q <= '0;
      ferr_got_q <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      vec_cnt_q  <= vec_cnt_d;
      err_cnt_q  <= err_cnt_d;
      ferr_idx_q <= ferr_idx_d;
      ferr_exp_q <= ferr_exp_d;
      ferr_got_q <= ferr_got_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
    end
  end

  assign done          = done_q;
  assign pass          = pass_q;
  assign vec_count     = vec_cnt_q;
  assign err_count     = err_cnt_q;
  assign first_err_idx = ferr_idx_q;
  assign first_err_exp = ferr_exp_q;
  assign first_err_got = ferr_got_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_result_checker.sv
module tb_alu_result_checker;
  import alu_pkg::*;

  localparam int W  = 8;
  localparam int CW = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [CW-1:0] num_vec = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0, b = '0, s = '0;
  logic          controle = 1'b0;
  logic          done, pass;
  logic [CW-1:0] vec_count, err_count, first_err_idx;
  logic [W-1:0]  first_err_exp, first_err_got;
  state_e        dbg_state;

  alu_result_checker #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .num_vec       (num_vec),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a             (a),
    .b             (b),
    .controle      (controle),
    .s             (s),
    .done          (done),
    .pass          (pass),
    .vec_count     (vec_count),
    .err_count     (err_count),
    .first_err_idx (first_err_idx),
    .first_err_exp (first_err_exp),
    .first_err_got (first_err_got),
    .dbg_state     (dbg_state)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  int n_vec  = 0;
  int n_chk  = 0;
  int n_miss = 0;

  // reference state of the current run
  int           m_vec;
  int           m_err;
  int           m_fidx;
  logic [W-1:0] m_fexp, m_fgot;
  int           m_num;

  function automatic logic [W-1:0] ref_res(logic [W-1:0] x, logic [W-1:0] y, logic op);
    logic [W:0] full;
    if (op) full = {1'b0, x} + {1'b0, y};
    else    full = {1'b0, x} + {1'b0, ~y} + 9'd1;
    return full[W-1:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear(input int n);
    m_vec = 0; m_err = 0; m_fidx = 0; m_fexp = '0; m_fgot = '0; m_num = n;
    exp_q.delete();
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic start_run(input int n);
    num_vec = CW'(n);
    start   = 1'b1;
    @(posedge clk); #1;
    model_clear(n);
    if (n == 0) begin
      check("empty_done", 32'(done), 32'd1);
      check("empty_pass", 32'(pass), 32'd1);
      check("empty_vec",  32'(vec_count), 32'd0);
      check("empty_state", 32'(dbg_state), 32'(ST_DONE));
    end else begin
      check("run_state", 32'(dbg_state), 32'(ST_RUN));
      check("run_done",  32'(done), 32'd0);
      check("run_ready", 32'(in_ready), 32'd1);
      check("run_vec0",  32'(vec_count), 32'd0);
      check("run_err0",  32'(err_count), 32'd0);
    end
    @(negedge clk);
    start   = 1'b0;
    num_vec = CW'($urandom_range(0, 7)); // must not matter after start
  endtask

  // Called at a negedge; returns at a negedge.
  task automatic send_vec(input logic [W-1:0] va, input logic [W-1:0] vb,
                          input logic op, input logic [W-1:0] vs,
                          input int gap, input bit pulse_start);
    bit ok;
    logic [W-1:0] e;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      if (pulse_start && g == 0) begin
        start   = 1'b1;
        num_vec = 16'd0;
      end
      a = W'($urandom); b = W'($urandom); s = W'($urandom);
      @(posedge clk); #1;
      if (pulse_start && g == 0) begin
        check("start_in_run_state", 32'(dbg_state), 32'(ST_RUN));
        check("start_in_run_vec", 32'(vec_count), 32'(m_vec));
      end
      @(negedge clk);
      start = 1'b0;
    end
    a = va; b = vb; controle = op; s = vs; in_valid = 1'b1;
    exp_q.push_back(ref_res(va, vb, op));
    ok = 1'b0;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        ok = 1'b1;
      end else begin
        @(posedge clk); @(negedge clk);
      end
    end
    if (!ok) begin
      n_chk++; n_miss++;
      $error("FAIL handshake_timeout: observed no in_ready expected in_ready within 50 cycles");
      void'(exp_q.pop_front());
      in_valid = 1'b0;
      return;
    end
    n_vec++;
    e = exp_q.pop_front();
    if (vs !== e) begin
      if (m_err == 0) begin
        m_fidx = m_vec; m_fexp = e; m_fgot = vs;
      end
      if (m_err < 65535) m_err++;
    end
    m_vec++;
    check("vec_count", 32'(vec_count), 32'(m_vec));
    check("err_count", 32'(err_count), 32'(m_err));
    if (m_vec == m_num) begin
      check("final_done",  32'(done), 32'd1);
      check("final_ready", 32'(in_ready), 32'd0);
      check("final_pass",  32'(pass), 32'(m_err == 0));
      if (m_err != 0) begin
        check("first_idx", 32'(first_err_idx), 32'(m_fidx));
        check("first_exp", 32'(first_err_exp), 32'(m_fexp));
        check("first_got", 32'(first_err_got), 32'(m_fgot));
      end
    end else begin
      check("mid_done", 32'(done), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    check({tag, "_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_pass"},  32'(pass), 32'd0);
    check({tag, "_vec"},   32'(vec_count), 32'd0);
    check({tag, "_err"},   32'(err_count), 32'd0);
    check({tag, "_fidx"},  32'(first_err_idx), 32'd0);
    check({tag, "_fexp"},  32'(first_err_exp), 32'd0);
    check({tag, "_fgot"},  32'(first_err_got), 32'd0);
  endtask

  initial begin
    // reset
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // in_valid while idle is ignored
    in_valid = 1'b1; a = 8'd1; b = 8'd1; controle = OP_ADD; s = 8'd9;
    @(posedge clk); #1;
    check("idle_ignore_vec", 32'(vec_count), 32'd0);
    check("idle_ignore_err", 32'(err_count), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;

    // basic add / sub
    start_run(2);
    send_vec(8'd2, 8'd1, OP_ADD, 8'd3, 0, 1'b0);
    send_vec(8'd2, 8'd1, OP_SUB, 8'd1, 0, 1'b0);

    // wrap-around, started from DONE
    start_run(2);
    send_vec(8'hFF, 8'h01, OP_ADD, 8'h00, 1, 1'b0);
    send_vec(8'h00, 8'h01, OP_SUB, 8'hFF, 0, 1'b0);

    // single mismatch on vector 1
    start_run(3);
    send_vec(8'd7, 8'd9, OP_ADD, 8'd16, 0, 1'b0);
    send_vec(8'd5, 8'd3, OP_SUB, 8'h03, 0, 1'b0);
    send_vec(8'd10, 8'd4, OP_SUB, 8'd6, 0, 1'b0);

    // two mismatches: capture keeps the first
    start_run(3);
    send_vec(8'h80, 8'h80, OP_ADD, 8'h01, 0, 1'b0);
    send_vec(8'h10, 8'h20, OP_SUB, 8'hF0, 0, 1'b0);
    send_vec(8'h33, 8'h11, OP_ADD, 8'h00, 0, 1'b0);

    // gaps plus start pulses during RUN
    start_run(3);
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] ra, rb;
      logic         rop;
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = 1'($urandom_range(0, 1));
      send_vec(ra, rb, rop, ref_res(ra, rb, rop), $urandom_range(1, 3), 1'b1);
    end
    check("gap_vec_total", 32'(vec_count), 32'd3);

    // empty run
    start_run(0);

    // reset mid-run after 1 of 4 vectors
    start_run(4);
    send_vec(8'd1, 8'd2, OP_ADD, 8'd3, 0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;

    // fresh run counts from zero
    start_run(2);
    send_vec(8'd200, 8'd100, OP_ADD, 8'd44, 0, 1'b0);
    send_vec(8'd3, 8'd200, OP_SUB, 8'd59, 2, 1'b0);

    // random run with occasional corrupted results
    start_run(6);
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] ra, rb, rs;
      logic         rop;
      ra  = W'($urandom);
      rb  = W'($urandom);
      rop = 1'($urandom_range(0, 1));
      rs  = ref_res(ra, rb, rop);
      if ($urandom_range(0, 2) == 0) rs = rs ^ W'($urandom_range(1, 255));
      send_vec(ra, rb, rop, rs, $urandom_range(0, 2), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

endmodule
